// File: rtl/stage_fe_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the registered FE->ID outputs.
// master = fetch stage, slave = memory/decode side.
interface stage_fe_if #(
  parameter int DATA_W = 32,
  parameter int INST_W = 32
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] inst;
  logic [DATA_W-1:0] out_pc;
  logic              flush;

  modport master (
    output imem_req, imem_addr, inst, out_pc, flush,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, inst, out_pc, flush,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/stage_fe.sv
// Instruction fetch: one outstanding imem request, 1-cycle ack-to-output latency, 1 instr/cycle peak.
// Decode stalls are absorbed by a one-entry holding buffer; fetch pauses while it is occupied.
module stage_fe #(
  parameter int                DATA_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stall,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  stage_fe_if.master        bus
);

  localparam logic [INST_W-1:0] NOP      = INST_W'(32'h0000_0013);
  localparam logic [DATA_W-1:0] PC_RESET = {RESET_PC[DATA_W-1:2], 2'b00};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_addr;
  logic [INST_W-1:0] r_buf_inst;
  logic [DATA_W-1:0] r_buf_pc;
  logic              r_buf_vld;
  logic [INST_W-1:0] r_inst;
  logic [DATA_W-1:0] r_out_pc;
  logic              r_flush;

  state_t            w_state_nxt;
  logic [DATA_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] w_addr_nxt;
  logic [INST_W-1:0] w_buf_inst_nxt;
  logic [DATA_W-1:0] w_buf_pc_nxt;
  logic              w_buf_vld_nxt;
  logic [INST_W-1:0] w_inst_nxt;
  logic [DATA_W-1:0] w_out_pc_nxt;
  logic              w_flush_nxt;

  logic              w_adv;
  logic              w_ack_req;
  logic              w_take;
  logic              w_ack_to_out;
  logic [DATA_W-1:0] w_addr_inc;
  logic [DATA_W-1:0] w_redir_pc;
  logic              w_unused;

  assign w_adv        = en && !stall && !redirect;
  assign w_ack_req    = (r_state == S_REQ) && bus.imem_ack;
  assign w_take       = w_ack_req && !redirect;
  assign w_ack_to_out = w_take && w_adv && !r_buf_vld;
  assign w_addr_inc   = r_addr + DATA_W'(4);
  assign w_redir_pc   = {redirect_pc[DATA_W-1:2], 2'b00};
  assign w_unused     = ^redirect_pc[1:0];

  always_comb begin
    w_inst_nxt     = r_inst;
    w_out_pc_nxt   = r_out_pc;
    w_flush_nxt    = r_flush;
    w_buf_inst_nxt = r_buf_inst;
    w_buf_pc_nxt   = r_buf_pc;
    w_buf_vld_nxt  = r_buf_vld;
    w_pc_nxt       = r_pc;

    if (redirect) begin
      w_inst_nxt  = NOP;
      w_flush_nxt = 1'b1;
    end else if (w_adv) begin
      if (r_buf_vld) begin
        w_inst_nxt    = r_buf_inst;
        w_out_pc_nxt  = r_buf_pc;
        w_flush_nxt   = 1'b0;
        w_buf_vld_nxt = 1'b0;
      end else if (w_ack_req) begin
        w_inst_nxt   = bus.imem_rdata;
        w_out_pc_nxt = r_addr;
        w_flush_nxt  = 1'b0;
      end else begin
        w_inst_nxt  = NOP;
        w_flush_nxt = 1'b1;
      end
    end

    // An accepted ack that cannot go straight to the output parks in the buffer.
    if (w_take && !w_ack_to_out) begin
      w_buf_inst_nxt = bus.imem_rdata;
      w_buf_pc_nxt   = r_addr;
      w_buf_vld_nxt  = 1'b1;
    end

    if (w_take) begin
      w_pc_nxt = w_addr_inc;
    end

    if (redirect) begin
      w_buf_vld_nxt = 1'b0;
      w_pc_nxt      = w_redir_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;

    unique case (r_state)
      S_IDLE: begin
        if (en && !redirect && !w_buf_vld_nxt) begin
          w_state_nxt = S_REQ;
          w_addr_nxt  = r_pc;
        end
      end
      S_REQ: begin
        if (bus.imem_ack) begin
          if (redirect) begin
            w_state_nxt = S_IDLE;
          end else if (w_ack_to_out) begin
            w_state_nxt = S_REQ;
            w_addr_nxt  = w_addr_inc;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (redirect) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.imem_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET;
      r_addr     <= PC_RESET;
      r_buf_inst <= NOP;
      r_buf_pc   <= PC_RESET;
      r_buf_vld  <= 1'b0;
      r_inst     <= NOP;
      r_out_pc   <= PC_RESET;
      r_flush    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_buf_pc   <= w_buf_pc_nxt;
      r_buf_vld  <= w_buf_vld_nxt;
      r_inst     <= w_inst_nxt;
      r_out_pc   <= w_out_pc_nxt;
      r_flush    <= w_flush_nxt;
    end
  end

  assign bus.imem_req  = (r_state != S_IDLE);
  assign bus.imem_addr = r_addr;
  assign bus.inst      = r_inst;
  assign bus.out_pc    = r_out_pc;
  assign bus.flush     = r_flush;

endmodule

// File: tb/tb_stage_fe.sv
// Bench for stage_fe: the driver acts as instruction memory and pushes every fetch that should survive
// into a queue; a monitor pops one entry per advancing edge and compares the FE->ID register.
module tb_stage_fe;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, stall, redirect;
  logic [31:0] redirect_pc;
  logic        rst2, en2, stall2, redirect2;
  logic [31:0] redirect_pc2;

  stage_fe_if #(.DATA_W(32), .INST_W(32)) ifc ();
  stage_fe_if #(.DATA_W(32), .INST_W(32)) ifc2 ();

  stage_fe #(.DATA_W(32), .INST_W(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .bus(ifc)
  );

  stage_fe #(.DATA_W(32), .INST_W(32), .RESET_PC(RPC2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .stall(stall2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .bus(ifc2)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_pc;
  bit          dead;
  int          total = 0;
  int          bad = 0;
  int          delivered = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), update the model, then wait for the next negedge.
  task automatic step(input bit e, input bit s, input bit r, input logic [31:0] rpc,
                      input bit a, input bit rs);
    en          = e;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    rst         = rs;
    ifc.imem_ack   = a;
    ifc.imem_rdata = a ? mem(ifc.imem_addr) : $urandom;
    if (rs) begin
      q.delete();
      exp_pc = RPC;
      dead   = 1'b0;
    end else begin
      if (a && ifc.imem_req) begin
        if (!dead && !r) begin
          chk("fetch_addr", ifc.imem_addr, exp_pc);
          q.push_back('{pc: exp_pc, inst: mem(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
        dead = 1'b0;
      end else if (r && ifc.imem_req) begin
        dead = 1'b1;
      end
      if (r) begin
        q.delete();
        exp_pc = {rpc[31:2], 2'b00};
      end
    end
    @(negedge clk);
  endtask

  logic        s_rst, s_red, s_adv;
  logic [31:0] ei = NOP;
  logic [31:0] ep = RPC;
  logic        ef = 1'b1;
  ent_t        e_pop;

  initial begin
    forever begin
      @(posedge clk);
      s_rst = rst;
      s_red = redirect;
      s_adv = en && !stall && !redirect;
      #1;
      if (s_rst) begin
        ei = NOP; ef = 1'b1; ep = RPC;
      end else if (s_red) begin
        ei = NOP; ef = 1'b1;
      end else if (s_adv) begin
        if (q.size() > 0) begin
          e_pop = q.pop_front();
          ei = e_pop.inst; ep = e_pop.pc; ef = 1'b0;
          delivered++;
        end else begin
          ei = NOP; ef = 1'b1;
        end
      end
      chk("out_reg", {ifc.inst, ifc.out_pc, ifc.flush}, {ei, ep, ef});
      if (s_rst)
        chk("rst_req", ifc.imem_req, 1'b0);
      else if (q.size() > 0)
        chk("buf_blocks_req", ifc.imem_req, 1'b0);
    end
  end

  initial begin
    bit          e, s, r, a, rs;
    logic [31:0] rpc;

    rst = 1'b1; en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ifc.imem_ack = 1'b0; ifc.imem_rdata = '0;
    exp_pc = RPC; dead = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;
    ifc2.imem_ack = 1'b0; ifc2.imem_rdata = '0;
    @(negedge clk);

    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    chk("rst_idle_req", ifc.imem_req, 1'b0);
    chk("rst_addr", ifc.imem_addr, RPC);

    // Back-to-back fetches with an ack in every request cycle.
    step(1, 0, 0, 0, 0, 0);
    chk("first_req", {ifc.imem_req, ifc.imem_addr}, {1'b1, 32'h100});
    step(1, 0, 0, 0, 1, 0);
    chk("stream_104", {ifc.imem_req, ifc.imem_addr}, {1'b1, 32'h104});
    step(1, 0, 0, 0, 1, 0);
    chk("stream_108", {ifc.imem_req, ifc.imem_addr}, {1'b1, 32'h108});
    step(1, 0, 0, 0, 1, 0);
    chk("stream_10c", {ifc.imem_req, ifc.imem_addr}, {1'b1, 32'h10C});
    chk("stream_out", {ifc.inst, ifc.out_pc, ifc.flush}, {mem(32'h108), 32'h108, 1'b0});

    // Stall across an ack: the instruction is buffered and fetch pauses.
    step(1, 1, 0, 0, 1, 0);
    chk("stall_req0", ifc.imem_req, 1'b0);
    step(1, 1, 0, 0, 0, 0);
    chk("stall_req1", ifc.imem_req, 1'b0);
    step(1, 1, 0, 0, 0, 0);
    chk("stall_hold", {ifc.inst, ifc.flush}, {mem(32'h108), 1'b0});
    step(1, 0, 0, 0, 0, 0);
    chk("drain_out", {ifc.inst, ifc.out_pc, ifc.flush}, {mem(32'h10C), 32'h10C, 1'b0});
    chk("resume_req", {ifc.imem_req, ifc.imem_addr}, {1'b1, 32'h110});

    // Redirect with the request still outstanding; its late ack is dropped.
    step(1, 0, 1, 32'h200, 0, 0);
    chk("drop_req", {ifc.imem_req, ifc.flush}, {1'b1, 1'b1});
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("drop_done", {ifc.imem_req, ifc.flush}, {1'b0, 1'b1});
    step(1, 0, 0, 0, 0, 0);
    chk("redir_req", {ifc.imem_req, ifc.imem_addr}, {1'b1, 32'h200});
    step(1, 0, 0, 0, 1, 0);

    // Redirect coinciding with an ack (unaligned target bits ignored).
    step(1, 0, 1, 32'h303, 1, 0);
    chk("redir_ack", {ifc.imem_req, ifc.flush}, {1'b0, 1'b1});
    step(1, 0, 0, 0, 0, 0);
    chk("redir_ack_req", {ifc.imem_req, ifc.imem_addr}, {1'b1, 32'h300});

    // Reset with a buffered instruction, then stray acks.
    step(1, 1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1);
    chk("rst_buf", {ifc.imem_req, ifc.imem_addr, ifc.flush}, {1'b0, RPC, 1'b1});
    step(0, 0, 0, 0, 1, 0);
    chk("stray_ack", {ifc.imem_req, ifc.flush}, {1'b0, 1'b1});
    step(1, 0, 0, 0, 0, 0);
    chk("post_rst_req", {ifc.imem_req, ifc.imem_addr}, {1'b1, RPC});
    step(1, 0, 0, 0, 1, 1);
    chk("rst_mid_req", ifc.imem_req, 1'b0);
    step(0, 0, 0, 0, 1, 0);
    chk("late_ack", {ifc.imem_req, ifc.flush}, {1'b0, 1'b1});

    // PC wrap on the second instance.
    rst2 = 1'b0; en2 = 1'b1;
    @(negedge clk);
    chk("wrap_first", {ifc2.imem_req, ifc2.imem_addr}, {1'b1, RPC2});
    ifc2.imem_ack = 1'b1; ifc2.imem_rdata = mem(RPC2);
    @(negedge clk);
    chk("wrap_addr", {ifc2.imem_req, ifc2.imem_addr}, {1'b1, 32'h0});
    chk("wrap_out", {ifc2.inst, ifc2.out_pc, ifc2.flush}, {mem(RPC2), RPC2, 1'b0});
    ifc2.imem_rdata = mem(32'h0);
    @(negedge clk);
    chk("wrap_out2", {ifc2.inst, ifc2.out_pc, ifc2.imem_addr}, {mem(32'h0), 32'h0, 32'h4});
    ifc2.imem_ack = 1'b0; en2 = 1'b0;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2500; i++) begin
      rs  = ($urandom % 150) == 0;
      r   = ($urandom % 12) == 0;
      rpc = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom_range(0, 1023);
      e   = ($urandom % 8) != 0;
      s   = ($urandom % 4) == 0;
      a   = ($urandom % 3) != 0;
      step(e, s, r, rpc, a, rs);
    end
    chk("liveness", delivered >= 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
